// File: rtl/l2_arbiter.sv
// -----------------------------------------------------------------------------
// l2_arbiter
//
// Shares the single L2 / physical-memory port between the I-cache miss path
// and the D-cache miss path. One line-sized read or write is outstanding at a
// time. The FSM has three states: IDLE, GRANT_I and GRANT_D.
//
// Optional build macro:
//   L2_ARB_ROUND_ROBIN_EN - when both sides request in the same IDLE cycle,
//                           grant the side that was not granted last.
//                           Without it, D always wins a contended grant.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   icache_read/write           I-side request strobes (write wins if both)
//   icache_address/wdata        I-side byte address and write line
//   icache_rdata/resp           I-side read line (broadcast) / completion
//   dcache_*                    same set of ports for the D side
//   l2_read/write               downstream strobes
//   l2_address/wdata            downstream line-aligned address and write line
//   l2_rdata/resp               downstream read line and completion
// -----------------------------------------------------------------------------
module l2_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  icache_read,
    input  logic                  icache_write,
    input  logic [ADDR_WIDTH-1:0] icache_address,
    input  logic [LINE_WIDTH-1:0] icache_wdata,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,

    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_address,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,

    output logic                  l2_read,
    output logic                  l2_write,
    output logic [ADDR_WIDTH-1:0] l2_address,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  l2_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic                    last_grant_reg;     // 0 = I, 1 = D
    logic                    op_read_reg;
    logic                    op_write_reg;
    // Only the line-select bits are kept; the offset bits are always
    // driven as zero on the L2 port.
    logic [ADDR_WIDTH-5:0]   line_addr_reg;
    logic [LINE_WIDTH-1:0]   wdata_reg;

    logic i_req, d_req, pick_d, start;

    assign i_req = icache_read | icache_write;
    assign d_req = dcache_read | dcache_write;
    assign start = (state_reg == IDLE) && (i_req || d_req);

`ifdef L2_ARB_ROUND_ROBIN_EN
    // Contended: go to the side opposite last_grant. Uncontended: the lone
    // requester wins.
    assign pick_d = d_req && (!i_req || !last_grant_reg);
`else
    // Fixed D-over-I priority; last_grant is tracked but has no effect here.
    assign pick_d = d_req;
    logic unused_last_grant;
    assign unused_last_grant = last_grant_reg;
`endif

    // Read data is broadcast; only resp qualifies it.
    assign icache_rdata = l2_rdata;
    assign dcache_rdata = l2_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b0;
            op_read_reg    <= 1'b0;
            op_write_reg   <= 1'b0;
            line_addr_reg  <= '0;
            wdata_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                last_grant_reg <= pick_d;
                if (pick_d) begin
                    op_write_reg  <= dcache_write;
                    op_read_reg   <= dcache_read & ~dcache_write;
                    line_addr_reg <= dcache_address[ADDR_WIDTH-1:4];
                    wdata_reg     <= dcache_wdata;
                end else begin
                    op_write_reg  <= icache_write;
                    op_read_reg   <= icache_read & ~icache_write;
                    line_addr_reg <= icache_address[ADDR_WIDTH-1:4];
                    wdata_reg     <= icache_wdata;
                end
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        l2_read     = 1'b0;
        l2_write    = 1'b0;
        l2_address  = '0;
        l2_wdata    = '0;
        icache_resp = 1'b0;
        dcache_resp = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // Spurious l2_resp is ignored here.
                if (start)
                    state_next = pick_d ? GRANT_D : GRANT_I;
            end
            GRANT_I, GRANT_D: begin
                l2_read    = op_read_reg;
                l2_write   = op_write_reg;
                l2_address = {line_addr_reg, 4'h0};
                l2_wdata   = wdata_reg;
                if (l2_resp) begin
                    state_next = IDLE;
                    // Reset wins over a same-cycle completion: no resp.
                    icache_resp = (state_reg == GRANT_I) && !reset;
                    dcache_resp = (state_reg == GRANT_D) && !reset;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l2_arbiter - directed, scoreboard-based bench for l2_arbiter.
// Expected transactions are queued when requests are driven and popped when
// the arbiter presents a transaction on the L2 port. Inputs are driven and
// outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_l2_arbiter;
    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          icache_read, icache_write, dcache_read, dcache_write;
    logic [AW-1:0] icache_address, dcache_address;
    logic [LW-1:0] icache_wdata, dcache_wdata, icache_rdata, dcache_rdata;
    logic          icache_resp, dcache_resp;
    logic          l2_read, l2_write, l2_resp;
    logic [AW-1:0] l2_address;
    logic [LW-1:0] l2_wdata, l2_rdata;

    l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .icache_read(icache_read), .icache_write(icache_write),
        .icache_address(icache_address), .icache_wdata(icache_wdata),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            side;   // 0 = I, 1 = D
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   rr_build;

    task automatic check(input string tag, input logic [LW-1:0] obs,
                         input logic [LW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
        $display("vec %0d %s obs=%h exp=%h", n_vec, tag, obs, exp);
    endtask

    task automatic push(input bit side, input bit wr, input logic [AW-1:0] addr,
                        input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
        txn_t t;
        t.side = side; t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        exp_q.push_back(t);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        icache_read = 0; icache_write = 0; dcache_read = 0; dcache_write = 0;
        l2_resp = 0;
        repeat (2) @(negedge clk);
        check("rst_l2_strobes", LW'({l2_read, l2_write}), '0);
        check("rst_l2_address", LW'(l2_address), '0);
        check("rst_resp", LW'({icache_resp, dcache_resp}), '0);
        reset = 1'b0;
    endtask

    // Wait (bounded) for an L2 strobe, pop the expected transaction and
    // compare the presented command.
    task automatic grant_check(input int exp_wait, output txn_t t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(l2_read || l2_write) && n < 20);
        check("grant_wait", LW'(n), LW'(exp_wait));
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            t.side = 0; t.wr = 0; t.addr = '0; t.wdata = '0; t.rdata = '0;
        end else begin
            t = exp_q.pop_front();
        end
        check("l2_write", LW'(l2_write), LW'(t.wr));
        check("l2_read", LW'(l2_read), LW'(!t.wr));
        check("l2_address", LW'(l2_address), LW'({t.addr[AW-1:4], 4'h0}));
        if (t.wr) check("l2_wdata", l2_wdata, t.wdata);
    endtask

    // Complete the granted transaction after lat cycles, then check the
    // turnaround cycle. drop[0]/drop[1] release the I/D request in M+1.
    task automatic complete(input txn_t t, input int lat, input bit [1:0] drop);
        repeat (lat) @(negedge clk);
        check("pre_resp", LW'({icache_resp, dcache_resp}), '0);
        l2_resp = 1'b1;
        l2_rdata = t.rdata;
        #1;
        check("icache_resp", LW'(icache_resp), LW'(!t.side));
        check("dcache_resp", LW'(dcache_resp), LW'(t.side));
        check("rdata", t.side ? dcache_rdata : icache_rdata, t.rdata);
        @(negedge clk);
        l2_resp = 1'b0;
        if (drop[0]) begin icache_read = 0; icache_write = 0; end
        if (drop[1]) begin dcache_read = 0; dcache_write = 0; end
        #1;
        check("turnaround", LW'({l2_read, l2_write}), '0);
    endtask

    txn_t t;
    logic [LW-1:0] pat_a5, pat_d;

    initial begin
`ifdef L2_ARB_ROUND_ROBIN_EN
        rr_build = 1'b1;
`else
        rr_build = 1'b0;
`endif
        pat_a5 = {16{8'hA5}};
        pat_d  = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        icache_address = '0; dcache_address = '0;
        icache_wdata = '0; dcache_wdata = '0; l2_rdata = '0;
        do_reset();

        // I-read alone, L2 answers after 3 cycles.
        push(0, 0, 16'h1236, '0, pat_a5);
        icache_address = 16'h1236; icache_read = 1;
        grant_check(1, t);
        complete(t, 3, 2'b01);

        // D-write.
        push(1, 1, 16'h4000, pat_d, '0);
        dcache_address = 16'h4000; dcache_wdata = pat_d; dcache_write = 1;
        grant_check(1, t);
        complete(t, 2, 2'b10);
        @(negedge clk);
        check("idle_after_dwrite", LW'({l2_read, l2_write}), '0);

        // Spurious l2_resp in IDLE.
        l2_resp = 1; #1;
        check("spurious_resp", LW'({icache_resp, dcache_resp}), '0);
        @(negedge clk);
        l2_resp = 0;
        check("spurious_idle", LW'({l2_read, l2_write}), '0);

        // Simultaneous I and D; D served first, I follows.
        do_reset();
        push(1, 0, 16'h2008, '0, 128'h11);
        push(0, 0, 16'h300C, '0, 128'h22);
        dcache_address = 16'h2008; dcache_read = 1;
        icache_address = 16'h300C; icache_read = 1;
        grant_check(1, t);
        complete(t, 2, 2'b10);
        grant_check(1, t);
        complete(t, 1, 2'b01);

        // Reset in the same cycle as l2_resp during GRANT_D.
        push(1, 0, 16'h5000, '0, '0);
        dcache_address = 16'h5000; dcache_read = 1;
        grant_check(1, t);
        l2_resp = 1; reset = 1; #1;
        check("rst_vs_resp_d", LW'(dcache_resp), '0);
        check("rst_vs_resp_i", LW'(icache_resp), '0);
        @(negedge clk);
        reset = 0; l2_resp = 0; dcache_read = 0;
        check("rst_mid_strobes", LW'({l2_read, l2_write}), '0);
        @(negedge clk);
        check("rst_mid_strobes2", LW'({l2_read, l2_write}), '0);

        // Both held continuously for 10 transactions.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            if (rr_build && (k % 2 == 1))
                push(0, 0, 16'h6010, '0, LW'(k));
            else
                push(1, 0, 16'h7020, '0, LW'(k + 100));
        end
        icache_address = 16'h6010; icache_read = 1;
        dcache_address = 16'h7020; dcache_read = 1;
        for (int k = 0; k < 10; k++) begin
            grant_check(1, t);
            complete(t, 1, (k == 9) ? 2'b11 : 2'b00);
        end
        @(negedge clk);
        check("final_idle", LW'({l2_read, l2_write}), '0);
        check("queue_drained", LW'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
